// File: rtl/mem_resp_stage.sv
// mem_resp_stage: memory-response pipeline stage between EXE and WB.
// Holds one instruction, waits for the data response that its accepted
// request still owes, aligns and extends load data, and discards responses
// that belong to requests orphaned by a flush.
// Optional feature: define MS_LOAD_FWD_EN to drive same-cycle forwarding of
// the final result on ms_fwd_*; otherwise those outputs are tied to zero.
module mem_resp_stage #(
  parameter int DROP_CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        es_to_ms_valid,
  output logic        ms_allowin,
  input  logic [31:0] es_pc,
  input  logic [31:0] es_result,
  input  logic [4:0]  es_dest,
  input  logic        es_gr_we,
  input  logic        es_mem_req,
  input  logic [4:0]  es_ld_op,
  input  logic        es_ex,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  input  logic        flush,
  input  logic        ws_allowin,
  output logic        ms_to_ws_valid,
  output logic [31:0] ms_pc,
  output logic [31:0] ms_final_result,
  output logic [4:0]  ms_dest,
  output logic        ms_gr_we,
  output logic        ms_ex,
  output logic        ms_ld_pending,
  output logic        ms_fwd_valid,
  output logic [4:0]  ms_fwd_dest,
  output logic [31:0] ms_fwd_data
);

  localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

  // Slot occupancy, response bookkeeping and registered payload
  logic                  ms_valid_q;
  logic                  captured_q;
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  logic [DROP_CNT_W-1:0] drop_cnt_d;
  logic [31:0]           rdata_buf_q;
  logic [31:0]           pc_q;
  logic [31:0]           result_q;
  logic [4:0]            dest_q;
  logic                  gr_we_q;
  logic                  mem_req_q;
  logic [4:0]            ld_op_q;
  logic                  ex_q;

  logic        usable_ok;
  logic        ms_ready_go;
  logic        drop_full;
  logic        accept;
  logic        in_wait;
  logic        drop_inc_wait;
  logic        drop_inc_acc;
  logic        drop_dec;
  logic [31:0] ld_word;
  logic [7:0]  lane_b [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] final_result;

  // A response is only usable by the slot when no orphans are ahead of it
  assign usable_ok   = data_sram_data_ok & (drop_cnt_q == '0);
  assign ms_ready_go = ~mem_req_q | captured_q | usable_ok;
  assign drop_full   = (drop_cnt_q == DROP_MAX);
  // Blocking on a full counter keeps a further orphan from overflowing it
  assign ms_allowin  = (~ms_valid_q | (ms_ready_go & ws_allowin)) & ~drop_full;
  assign accept      = es_to_ms_valid & ms_allowin;
  assign in_wait     = ms_valid_q & mem_req_q & ~captured_q;

  assign drop_inc_wait = flush & in_wait & ~usable_ok;
  assign drop_inc_acc  = flush & accept & es_mem_req;
  assign drop_dec      = data_sram_data_ok & (drop_cnt_q != '0);
  assign drop_cnt_d    = drop_cnt_q + DROP_CNT_W'(drop_inc_wait)
                       + DROP_CNT_W'(drop_inc_acc) - DROP_CNT_W'(drop_dec);

  // Fresh response is used directly in its arrival cycle, the buffer afterwards
  assign ld_word = captured_q ? rdata_buf_q : data_sram_rdata;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_b[gi] = ld_word[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = lane_b[result_q[1:0]];
  assign sel_half = result_q[1] ? {lane_b[3], lane_b[2]} : {lane_b[1], lane_b[0]};

  // Load alignment and extension; ld_op is one-hot {b, bu, h, hu, w}
  always_comb begin
    final_result = result_q;
    if (ld_op_q[4])      final_result = {{24{sel_byte[7]}}, sel_byte};
    else if (ld_op_q[3]) final_result = {24'd0, sel_byte};
    else if (ld_op_q[2]) final_result = {{16{sel_half[15]}}, sel_half};
    else if (ld_op_q[1]) final_result = {16'd0, sel_half};
    else if (ld_op_q[0]) final_result = ld_word;
  end

  // Slot valid, payload capture, response buffer and orphan counter
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_q  <= 1'b0;
      captured_q  <= 1'b0;
      drop_cnt_q  <= '0;
      rdata_buf_q <= '0;
      pc_q        <= '0;
      result_q    <= '0;
      dest_q      <= '0;
      gr_we_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      ld_op_q     <= '0;
      ex_q        <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;

      if (flush)                            ms_valid_q <= 1'b0;
      else if (accept)                      ms_valid_q <= 1'b1;
      else if (ms_to_ws_valid & ws_allowin) ms_valid_q <= 1'b0;

      // An instruction arriving under flush is discarded, not loaded
      if (accept & ~flush) begin
        pc_q       <= es_pc;
        result_q   <= es_result;
        dest_q     <= es_dest;
        gr_we_q    <= es_gr_we;
        mem_req_q  <= es_mem_req;
        ld_op_q    <= es_ld_op;
        ex_q       <= es_ex;
        captured_q <= 1'b0;
      end else if (usable_ok & in_wait) begin
        captured_q <= 1'b1;
      end

      if (usable_ok & in_wait) rdata_buf_q <= data_sram_rdata;
    end
  end

  assign ms_to_ws_valid  = ms_valid_q & ms_ready_go;
  assign ms_ld_pending   = ms_valid_q & (|ld_op_q) & ~ms_ready_go;
  assign ms_pc           = pc_q;
  assign ms_final_result = final_result;
  assign ms_dest         = dest_q;
  assign ms_gr_we        = gr_we_q & ~ex_q;
  assign ms_ex           = ex_q;

`ifdef MS_LOAD_FWD_EN
  assign ms_fwd_valid = ms_valid_q & ms_gr_we & ms_ready_go & ~ex_q;
  assign ms_fwd_dest  = dest_q;
  assign ms_fwd_data  = final_result;
`else
  assign ms_fwd_valid = 1'b0;
  assign ms_fwd_dest  = '0;
  assign ms_fwd_data  = '0;
`endif

endmodule

// File: tb/tb_mem_resp_stage.sv
// Testbench for mem_resp_stage: directed test-plan steps followed by random
// traffic, checked against a response-ownership reference model.
module tb_mem_resp_stage;

  localparam int DW   = 1;
  localparam int MAXD = (1 << DW) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        es_to_ms_valid = 1'b0;
  logic        ms_allowin;
  logic [31:0] es_pc = '0;
  logic [31:0] es_result = '0;
  logic [4:0]  es_dest = '0;
  logic        es_gr_we = 1'b0;
  logic        es_mem_req = 1'b0;
  logic [4:0]  es_ld_op = '0;
  logic        es_ex = 1'b0;
  logic        data_sram_data_ok = 1'b0;
  logic [31:0] data_sram_rdata = '0;
  logic        flush = 1'b0;
  logic        ws_allowin = 1'b1;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic [31:0] ms_final_result;
  logic [4:0]  ms_dest;
  logic        ms_gr_we;
  logic        ms_ex;
  logic        ms_ld_pending;
  logic        ms_fwd_valid;
  logic [4:0]  ms_fwd_dest;
  logic [31:0] ms_fwd_data;

  always #5 clk = ~clk;

  mem_resp_stage #(.DROP_CNT_W(DW)) dut (
    .clk(clk), .reset(reset),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_result(es_result), .es_dest(es_dest),
    .es_gr_we(es_gr_we), .es_mem_req(es_mem_req), .es_ld_op(es_ld_op),
    .es_ex(es_ex), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .flush(flush), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc),
    .ms_final_result(ms_final_result), .ms_dest(ms_dest),
    .ms_gr_we(ms_gr_we), .ms_ex(ms_ex), .ms_ld_pending(ms_ld_pending),
    .ms_fwd_valid(ms_fwd_valid), .ms_fwd_dest(ms_fwd_dest),
    .ms_fwd_data(ms_fwd_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who owns each outstanding response (-1 = orphan),
  // plus the instruction currently held by the stage.
  int          owners[$];
  int          next_id = 0;
  logic        m_valid = 1'b0;
  int          m_id = -10;
  logic [31:0] m_pc, m_res;
  logic [4:0]  m_dest, m_ld;
  logic        m_we, m_mr, m_ex;
  logic        m_have = 1'b0;
  logic [31:0] m_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] load_value(input logic [4:0] ld, input logic [31:0] addr,
                                             input logic [31:0] word, input logic [31:0] res);
    int a;
    logic [7:0]  b;
    logic [15:0] h;
    a = int'(addr[1:0]);
    b = 8'(word >> (8 * a));
    h = 16'(word >> (16 * (a / 2)));
    case (ld)
      5'b10000: return {{24{b[7]}}, b};
      5'b01000: return {24'd0, b};
      5'b00100: return {{16{h[15]}}, h};
      5'b00010: return {16'd0, h};
      5'b00001: return word;
      default:  return res;
    endcase
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model
  task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] res,
                     input logic [4:0] dest, input logic we, input logic mr,
                     input logic [4:0] ld, input logic ex, input logic dok,
                     input logic [31:0] rd, input logic fl, input logic wsa);
    logic has, exp_ai, acc, exp_fv;
    int orph, owner;
    logic [31:0] exp_res;
    @(posedge clk); #1;
    es_to_ms_valid = v; es_pc = pc; es_result = res; es_dest = dest;
    es_gr_we = we; es_mem_req = mr; es_ld_op = ld; es_ex = ex;
    data_sram_data_ok = dok; data_sram_rdata = rd; flush = fl; ws_allowin = wsa;
    #3;
    orph = 0;
    foreach (owners[i]) if (owners[i] < 0) orph++;
    owner   = (dok && owners.size() > 0) ? owners[0] : -2;
    has     = m_valid && (!m_mr || m_have || owner == m_id);
    exp_ai  = (!m_valid || (has && wsa)) && (orph < MAXD);
    exp_res = load_value(m_ld, m_res, m_have ? m_data : rd, m_res);
    chk("allowin", {31'd0, ms_allowin}, {31'd0, exp_ai});
    chk("to_ws_valid", {31'd0, ms_to_ws_valid}, {31'd0, has});
    chk("ld_pending", {31'd0, ms_ld_pending}, {31'd0, m_valid && m_ld != 0 && !has});
    if (has) begin
      chk("pc", ms_pc, m_pc);
      if (!(m_ld != 0 && !m_mr)) chk("final_result", ms_final_result, exp_res);
      chk("dest", {27'd0, ms_dest}, {27'd0, m_dest});
      chk("gr_we", {31'd0, ms_gr_we}, {31'd0, m_we && !m_ex});
      chk("ex", {31'd0, ms_ex}, {31'd0, m_ex});
      if (wsa) $display("WB pc=%h result=%h dest=%0d we=%0b ex=%0b", ms_pc, ms_final_result,
                        ms_dest, ms_gr_we, ms_ex);
    end
`ifdef MS_LOAD_FWD_EN
    exp_fv = has && m_we && !m_ex;
    chk("fwd_valid", {31'd0, ms_fwd_valid}, {31'd0, exp_fv});
    if (exp_fv && !(m_ld != 0 && !m_mr)) begin
      chk("fwd_dest", {27'd0, ms_fwd_dest}, {27'd0, m_dest});
      chk("fwd_data", ms_fwd_data, exp_res);
    end
`else
    exp_fv = 1'b0;
    chk("fwd_valid", {31'd0, ms_fwd_valid}, {31'd0, exp_fv});
    chk("fwd_dest", {27'd0, ms_fwd_dest}, 32'd0);
    chk("fwd_data", ms_fwd_data, 32'd0);
`endif
    acc = v && exp_ai;
    if (dok && owners.size() > 0) begin
      owner = owners.pop_front();
      if (m_valid && owner == m_id) begin
        m_have = 1'b1;
        m_data = rd;
      end
    end
    if (fl) begin
      if (m_valid && m_mr && !m_have)
        foreach (owners[i]) if (owners[i] == m_id) owners[i] = -1;
      if (acc && mr) owners.push_back(-1);
      m_valid = 1'b0;
    end else if (acc) begin
      m_valid = 1'b1; m_id = next_id; next_id++;
      m_pc = pc; m_res = res; m_dest = dest; m_we = we; m_mr = mr; m_ld = ld; m_ex = ex;
      m_have = 1'b0;
      if (mr) owners.push_back(m_id);
    end else if (has && wsa) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic idle(input logic dok, input logic [31:0] rd, input logic fl, input logic wsa);
    cyc(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, dok, rd, fl, wsa);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b0; flush = 1'b0;
    ws_allowin = 1'b1;
    @(posedge clk); #4;
    chk("rst_allowin", {31'd0, ms_allowin}, 32'd1);
    chk("rst_to_ws", {31'd0, ms_to_ws_valid}, 32'd0);
    chk("rst_ld_pending", {31'd0, ms_ld_pending}, 32'd0);
    chk("rst_fwd_valid", {31'd0, ms_fwd_valid}, 32'd0);
    chk("rst_pc", ms_pc, 32'd0);
    chk("rst_result", ms_final_result, 32'd0);
    chk("rst_dest", {27'd0, ms_dest}, 32'd0);
    chk("rst_gr_we", {31'd0, ms_gr_we}, 32'd0);
    chk("rst_ex", {31'd0, ms_ex}, 32'd0);
    reset = 1'b0;
    owners.delete();
    m_valid = 1'b0;
  endtask

  initial begin
    logic [4:0] ld_tab [7];
    logic [4:0] ld;
    logic v, mr, ex, dok, fl, wsa;
    ld_tab[0] = 5'b00000; ld_tab[1] = 5'b00000; ld_tab[2] = 5'b10000;
    ld_tab[3] = 5'b01000; ld_tab[4] = 5'b00100; ld_tab[5] = 5'b00010;
    ld_tab[6] = 5'b00001;

    do_reset();

    // ALU op passes through in one cycle
    cyc(1, 32'h100, 32'h1234_5678, 5'd3, 1, 0, 5'b00000, 0, 0, 0, 0, 1);
    idle(0, 0, 0, 1);
    chk("alu_valid", {31'd0, ms_to_ws_valid}, 32'd1);
    chk("alu_result", ms_final_result, 32'h1234_5678);

    // ld_b at lane 3, data_ok three cycles after accept
    cyc(1, 32'h104, 32'h0000_1003, 5'd4, 1, 1, 5'b10000, 0, 0, 0, 0, 1);
    idle(0, 0, 0, 1);
    chk("ldb_pending", {31'd0, ms_ld_pending}, 32'd1);
    idle(0, 0, 0, 1);
    idle(1, 32'h80AA_BBCC, 0, 1);
    chk("ldb_valid", {31'd0, ms_to_ws_valid}, 32'd1);
    chk("ldb_result", ms_final_result, 32'hFFFF_FF80);

    // ld_bu, same scenario
    cyc(1, 32'h108, 32'h0000_1003, 5'd4, 1, 1, 5'b01000, 0, 0, 0, 0, 1);
    idle(0, 0, 0, 1);
    idle(0, 0, 0, 1);
    idle(1, 32'h80AA_BBCC, 0, 1);
    chk("ldbu_result", ms_final_result, 32'h0000_0080);

    // ld_hu at lane 2 with WB stalled for two cycles
    cyc(1, 32'h10C, 32'h0000_2002, 5'd5, 1, 1, 5'b00010, 0, 0, 0, 0, 1);
    idle(0, 0, 0, 1);
    idle(1, 32'hBEEF_0001, 0, 0);
    chk("ldhu_result_dok", ms_final_result, 32'h0000_BEEF);
    idle(0, 32'h0, 0, 0);
    chk("ldhu_held", ms_final_result, 32'h0000_BEEF);
    chk("ldhu_stall_allowin", {31'd0, ms_allowin}, 32'd0);
    idle(0, 32'h0, 0, 1);
    chk("ldhu_deliver", ms_final_result, 32'h0000_BEEF);

    // Flush in WAIT: the first response is dropped, new load gets the second
    cyc(1, 32'h110, 32'h0000_3000, 5'd6, 1, 1, 5'b00001, 0, 0, 0, 0, 1);
    idle(0, 0, 0, 1);
    idle(0, 0, 1, 1);
    cyc(1, 32'h114, 32'h0000_3004, 5'd7, 1, 1, 5'b00001, 0, 0, 0, 0, 1);
    chk("orphan_block", {31'd0, ms_allowin}, 32'd0);
    idle(1, 32'hDEAD_0000, 0, 1);
    chk("orphan_drop_valid", {31'd0, ms_to_ws_valid}, 32'd0);
    cyc(1, 32'h118, 32'h0000_3004, 5'd7, 1, 1, 5'b00001, 0, 0, 0, 0, 1);
    chk("orphan_recover", {31'd0, ms_allowin}, 32'd1);
    idle(1, 32'hCAFE_F00D, 0, 1);
    chk("second_resp", ms_final_result, 32'hCAFE_F00D);

    // Flush while accepting a request-carrying instruction
    cyc(1, 32'h11C, 32'h0000_4000, 5'd8, 1, 1, 5'b00001, 0, 0, 0, 1, 1);
    idle(0, 0, 0, 1);
    chk("acc_flush_block", {31'd0, ms_allowin}, 32'd0);
    idle(1, 32'h1111_1111, 0, 1);
    idle(0, 0, 0, 1);
    chk("acc_flush_recover", {31'd0, ms_allowin}, 32'd1);

    // Flush and usable data_ok together: consumed, no orphan
    cyc(1, 32'h120, 32'h0000_5000, 5'd9, 1, 1, 5'b00001, 0, 0, 0, 0, 1);
    idle(0, 0, 0, 1);
    idle(1, 32'h5555_5555, 1, 1);
    idle(0, 0, 0, 1);
    chk("flush_dok_no_orphan", {31'd0, ms_allowin}, 32'd1);

    // Exception on a load: write enable suppressed, no forwarding
    cyc(1, 32'h124, 32'h0000_6000, 5'd10, 1, 0, 5'b00001, 1, 0, 0, 0, 1);
    idle(0, 0, 0, 1);
    chk("ex_gr_we", {31'd0, ms_gr_we}, 32'd0);
    chk("ex_flag", {31'd0, ms_ex}, 32'd1);
    chk("ex_fwd", {31'd0, ms_fwd_valid}, 32'd0);

    // data_ok and accept in the same cycle: response goes to the old load
    cyc(1, 32'h128, 32'h0000_7000, 5'd11, 1, 1, 5'b00001, 0, 0, 0, 0, 1);
    idle(0, 0, 0, 1);
    cyc(1, 32'h12C, 32'h0000_7004, 5'd12, 1, 1, 5'b00001, 0, 1, 32'hAAAA_5555, 0, 1);
    chk("same_cycle_old", ms_final_result, 32'hAAAA_5555);
    chk("same_cycle_allowin", {31'd0, ms_allowin}, 32'd1);
    idle(0, 0, 0, 1);
    idle(1, 32'h0BAD_BEEF, 0, 1);
    chk("same_cycle_new", ms_final_result, 32'h0BAD_BEEF);

    // Reset mid-WAIT
    cyc(1, 32'h130, 32'h0000_8000, 5'd13, 1, 1, 5'b00001, 0, 0, 0, 0, 1);
    idle(0, 0, 0, 1);
    do_reset();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      ld  = ld_tab[$urandom_range(0, 6)];
      ex  = ($urandom_range(0, 15) == 0);
      mr  = ex ? 1'b0 : ((ld != 0) ? 1'b1 : ($urandom_range(0, 3) == 0));
      v   = ($urandom_range(0, 3) != 0);
      dok = (owners.size() > 0) && ($urandom_range(0, 1) == 1);
      fl  = ($urandom_range(0, 11) == 0);
      wsa = ($urandom_range(0, 3) != 0);
      cyc(v, $urandom, $urandom, 5'($urandom), 1'($urandom), mr, ld, ex,
          dok, $urandom, fl, wsa);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
